// File: rtl/snake_pkg.sv
// snake_pkg: shared coordinate type, screen/colour/direction constants and apple placement helper
package snake_pkg;
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
  } coord_t;
  typedef enum logic [1:0] {DIR_RIGHT = 2'd0, DIR_LEFT = 2'd1, DIR_UP = 2'd2, DIR_DOWN = 2'd3} dir_e;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int GRID = 4;
  localparam logic [7:0] MAX_X = 8'(SCREEN_W - GRID);
  localparam logic [6:0] MAX_Y = 7'(SCREEN_H - GRID);
  localparam coord_t DEFAULT_HEAD = '{x: 8'd80, y: 7'd60};
  localparam coord_t DEFAULT_APPLE = '{x: 8'd120, y: 7'd60};
  localparam coord_t SENTINEL = '{x: 8'd255, y: 7'd127};
  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_RED = 3'b100;
  function automatic coord_t apple_of(input logic [15:0] l);
    return '{x: 8'((l % 16'd40) * 16'd4), y: 7'({2'b0, l[12:8] % 5'd30} * 7'd4)};
  endfunction
endpackage

// File: rtl/snake_body_ram.sv
// snake_body_ram: body segment store, one synchronous write port and a combinational read port
module snake_body_ram import snake_pkg::*; #(
  parameter int LEN_W = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [LEN_W-1:0] addr,
  input  coord_t           wdata,
  output coord_t           rdata
);
  coord_t mem [2**LEN_W];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/snake_datapath.sv
// snake_datapath: snake game datapath (body RAM, head/apple/direction, plotter); SNAKE_WRAP_EDGES_EN makes edges wrap
module snake_datapath import snake_pkg::*; #(
  parameter int          LEN_W     = 9,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] dir,
  input  logic       reset_ram,
  input  logic       reset_address,
  input  logic       inc_address,
  input  logic       load_default_head,
  input  logic       load_part_into_ram,
  input  logic       load_ram_into_current,
  input  logic       draw_ram,
  input  logic       draw_apple,
  input  logic       erase_trail,
  input  logic       update_head,
  input  logic       inc_check,
  input  logic       load_head_into_prev,
  input  logic       load_prev_into_ram,
  input  logic       load_current_into_prev,
  input  logic [3:0] drawStatus,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       has_collided,
  output logic       isDead
);
  logic [LEN_W-1:0] addr_q, addr_d;
  coord_t head_q, head_d, cur_q, cur_d, prev_q, prev_d, tail_q, tail_d, apple_q, apple_d;
  coord_t rd, ram_wd, step, base;
  dir_e dir_q, dir_d, ndir;
  logic [15:0] lfsr_q, lfsr_d;
  logic dead_q, dead_d, hit_q, hit_d, coll_q, coll_d, plot_q, plot_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] col_q, col_d;
  logic ram_we, edge_die, eat, drawing;
  snake_body_ram #(.LEN_W(LEN_W)) u_ram (.clk(clk), .we(ram_we), .addr(addr_q), .wdata(ram_wd), .rdata(rd));
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    addr_d = reset_address ? '0 : addr_q + LEN_W'(inc_address);
    ram_we = reset_ram | load_part_into_ram | load_prev_into_ram;
    ram_wd = reset_ram ? SENTINEL : load_part_into_ram ? cur_q : prev_q;
    ndir = (dir == (dir_q ^ 2'd1)) ? dir_q : dir_e'(dir);
`ifdef SNAKE_WRAP_EDGES_EN
    step.x = ndir == DIR_RIGHT ? (head_q.x == MAX_X ? 8'd0 : head_q.x + 8'd4) :
             ndir == DIR_LEFT  ? (head_q.x == 8'd0 ? MAX_X : head_q.x - 8'd4) : head_q.x;
    step.y = ndir == DIR_DOWN ? (head_q.y == MAX_Y ? 7'd0 : head_q.y + 7'd4) :
             ndir == DIR_UP   ? (head_q.y == 7'd0 ? MAX_Y : head_q.y - 7'd4) : head_q.y;
    edge_die = 1'b0;
`else
    step.x = ndir == DIR_RIGHT ? head_q.x + 8'd4 : ndir == DIR_LEFT ? head_q.x - 8'd4 : head_q.x;
    step.y = ndir == DIR_DOWN ? head_q.y + 7'd4 : ndir == DIR_UP ? head_q.y - 7'd4 : head_q.y;
    edge_die = step.x > MAX_X || step.y > MAX_Y;
`endif
    eat = inc_check && head_q == apple_q;
    head_d = load_default_head ? DEFAULT_HEAD : update_head ? step : head_q;
    dir_d = load_default_head ? DIR_RIGHT : update_head ? ndir : dir_q;
    cur_d = load_default_head ? DEFAULT_HEAD : load_part_into_ram ? {cur_q.x - 8'd4, cur_q.y} :
            load_ram_into_current ? rd : cur_q;
    prev_d = load_head_into_prev ? head_q : load_current_into_prev ? cur_q : prev_q;
    tail_d = load_current_into_prev ? cur_q : tail_q;
    apple_d = eat ? apple_of(lfsr_d) : apple_q;
    hit_d = (load_ram_into_current && addr_q != '0 && rd == head_q && rd != SENTINEL) ||
            (hit_q && !load_head_into_prev);
    dead_d = (reset_ram || load_default_head) ? 1'b0 :
             dead_q || (update_head && edge_die) || (inc_check && !eat && hit_q);
    coll_d = eat;
    drawing = draw_ram | draw_apple | erase_trail;
    base = draw_ram ? cur_q : draw_apple ? apple_q : tail_q;
    x_d = drawing ? base.x + {6'b0, drawStatus[1:0]} : x_q;
    y_d = drawing ? base.y + {5'b0, drawStatus[3:2]} : y_q;
    col_d = draw_ram ? COL_GREEN : draw_apple ? COL_RED : erase_trail ? COL_BLACK : col_q;
    plot_d = drawing && base != SENTINEL;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      head_q <= DEFAULT_HEAD;
      cur_q <= DEFAULT_HEAD;
      prev_q <= DEFAULT_HEAD;
      tail_q <= SENTINEL;
      apple_q <= DEFAULT_APPLE;
      dir_q <= DIR_RIGHT;
      lfsr_q <= LFSR_SEED;
      dead_q <= 1'b0;
      hit_q <= 1'b0;
      coll_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      col_q <= '0;
      plot_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      head_q <= head_d;
      cur_q <= cur_d;
      prev_q <= prev_d;
      tail_q <= tail_d;
      apple_q <= apple_d;
      dir_q <= dir_d;
      lfsr_q <= lfsr_d;
      dead_q <= dead_d;
      hit_q <= hit_d;
      coll_q <= coll_d;
      x_q <= x_d;
      y_q <= y_d;
      col_q <= col_d;
      plot_q <= plot_d;
    end
  end
  assign x = x_q;
  assign y = y_q;
  assign colour = col_q;
  assign plot = plot_q;
  assign has_collided = coll_q;
  assign isDead = dead_q;
endmodule

// File: tb/tb_snake_datapath.sv
// tb_snake_datapath: scoreboard bench for snake_datapath drawing, movement, collision and death
module tb_snake_datapath;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] dir;
  logic reset_ram, reset_address, inc_address, load_default_head, load_part_into_ram;
  logic load_ram_into_current, draw_ram, draw_apple, erase_trail;
  logic update_head, inc_check, load_head_into_prev, load_prev_into_ram, load_current_into_prev;
  logic [3:0] ds;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic plot, has_collided, isDead;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic p;
  } exp_t;
  exp_t sb[$];
  snake_datapath dut (
    .clk(clk), .reset(reset), .dir(dir), .reset_ram(reset_ram), .reset_address(reset_address),
    .inc_address(inc_address), .load_default_head(load_default_head),
    .load_part_into_ram(load_part_into_ram), .load_ram_into_current(load_ram_into_current),
    .draw_ram(draw_ram), .draw_apple(draw_apple), .erase_trail(erase_trail),
    .update_head(update_head), .inc_check(inc_check), .load_head_into_prev(load_head_into_prev),
    .load_prev_into_ram(load_prev_into_ram), .load_current_into_prev(load_current_into_prev),
    .drawStatus(ds), .x(x), .y(y), .colour(colour), .plot(plot),
    .has_collided(has_collided), .isDead(isDead)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    {reset_ram, reset_address, inc_address, load_default_head, load_part_into_ram} = '0;
    {load_ram_into_current, draw_ram, draw_apple, erase_trail} = '0;
    {update_head, inc_check, load_head_into_prev, load_prev_into_ram, load_current_into_prev} = '0;
  endtask
  task automatic draw(input int kind, input logic [3:0] s, input logic [7:0] bx, input logic [6:0] by, input logic p);
    exp_t e;
    e.x = bx + {6'b0, s[1:0]};
    e.y = by + {5'b0, s[3:2]};
    e.c = kind == 0 ? 3'b010 : kind == 1 ? 3'b100 : 3'b000;
    e.p = p;
    sb.push_back(e);
    ds = s;
    draw_ram = kind == 0;
    draw_apple = kind == 1;
    erase_trail = kind == 2;
    tick;
    clr;
    e = sb.pop_front();
    chk("plot", plot, e.p);
    if (e.p) begin
      chk("x", x, e.x);
      chk("y", y, e.y);
      chk("colour", colour, e.c);
    end
  endtask
  task automatic show_head(input logic [3:0] s, input logic [7:0] hx, input logic [6:0] hy);
    reset_address = 1; load_head_into_prev = 1; tick; clr;
    load_prev_into_ram = 1; tick; clr;
    load_ram_into_current = 1; tick; clr;
    draw(0, s, hx, hy, 1'b1);
  endtask
  task automatic move(input logic [1:0] d, input int n);
    dir = d;
    for (int i = 0; i < n; i++) begin
      update_head = 1; tick; clr;
    end
  endtask
  initial begin
    clr;
    dir = 0; ds = 0; reset = 1;
    tick; tick;
    reset = 0;
    chk("rst_x", x, 0); chk("rst_y", y, 0); chk("rst_col", colour, 0); chk("rst_plot", plot, 0);
    chk("rst_coll", has_collided, 0); chk("rst_dead", isDead, 0);
    draw(1, 4'd0, 8'd120, 7'd60, 1'b1);
    draw(2, 4'd0, 8'd255, 7'd127, 1'b0);
    draw(0, 4'd0, 8'd80, 7'd60, 1'b1);
    for (int i = 0; i < 512; i++) begin
      reset_ram = 1; inc_address = 1; tick; clr;
    end
    reset_address = 1; tick; clr;
    for (int i = 0; i < 512; i++) begin
      load_ram_into_current = 1; inc_address = 1; tick; clr;
      draw(0, 4'(i), 8'd255, 7'd127, 1'b0);
    end
    reset_address = 1; load_default_head = 1; tick; clr;
    for (int i = 0; i < 3; i++) begin
      load_part_into_ram = 1; inc_address = 1; tick; clr;
    end
    reset_address = 1; tick; clr;
    for (int i = 0; i < 4; i++) begin
      load_ram_into_current = 1; inc_address = 1; tick; clr;
      draw(0, 4'd0, 8'(80 - 4 * i), 7'd60, i < 3);
    end
    move(2'd0, 9);
    inc_check = 1; tick; clr;
    chk("no_eat", has_collided, 0);
    move(2'd0, 1);
    inc_check = 1; tick; clr;
    chk("eat_pulse", has_collided, 1);
    tick;
    chk("eat_once", has_collided, 0);
    chk("eat_alive", isDead, 0);
    draw_apple = 1; tick; clr;
    chk("apple_plot", plot, 1);
    chk("apple_grid", {x[1:0], y[1:0]}, 0);
    chk("apple_onscr", (x <= 8'd156) && (y <= 7'd116), 1);
    move(2'd0, 9);
    chk("edge_alive", isDead, 0);
    move(2'd0, 1);
`ifdef SNAKE_WRAP_EDGES_EN
    chk("wrap_alive", isDead, 0);
    show_head(4'd0, 8'd0, 7'd60);
`else
    chk("edge_dead", isDead, 1);
    tick;
    chk("dead_hold", isDead, 1);
`endif
    load_default_head = 1; tick; clr;
    chk("dead_clr", isDead, 0);
    move(2'd1, 1);
    show_head(4'd0, 8'd84, 7'd60);
    move(2'd2, 1);
    show_head(4'd0, 8'd84, 7'd56);
    move(2'd3, 1);
    show_head(4'd0, 8'd84, 7'd52);
    move(2'd2, 8);
    move(2'd1, 11);
    show_head(4'b1011, 8'd40, 7'd20);
    inc_check = 1; tick; clr;
    chk("addr0_nohit", isDead, 0);
    inc_address = 1; tick; clr;
    load_prev_into_ram = 1; tick; clr;
    load_ram_into_current = 1; tick; clr;
    chk("hit_pending", isDead, 0);
    inc_check = 1; tick; clr;
    chk("self_hit", isDead, 1);
    reset_ram = 1; tick; clr;
    chk("ram_clr_dead", isDead, 0);
    move(2'd3, 2);
    reset = 1; tick; reset = 0;
    chk("mid_rst_x", x, 0); chk("mid_rst_plot", plot, 0); chk("mid_rst_dead", isDead, 0);
    draw(1, 4'd0, 8'd120, 7'd60, 1'b1);
    draw(2, 4'd5, 8'd255, 7'd127, 1'b0);
    show_head(4'd0, 8'd80, 7'd60);
    load_current_into_prev = 1; tick; clr;
    draw(2, 4'd6, 8'd80, 7'd60, 1'b1);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/snake_datapath.md
# snake_datapath

Datapath responder for the snake game controller. It holds the snake-body RAM, the head, current, previous and tail coordinate registers, the apple position and the direction latch. It executes the controller's one-hot strobes and drives the VGA plotter (x, y, colour, plot). It reports `has_collided` and `isDead` back to the controller.

## Interface
- `LEN_W`, default 9: body RAM address width; depth is 2^LEN_W segments.
- `LFSR_SEED`, default 16'hACE1: apple LFSR reset value; must be nonzero.
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high reset.
- `dir`  in  2: requested direction, 0=right, 1=left, 2=up, 3=down.
- `reset_ram`, `reset_address`, `inc_address`, `load_default_head`, `load_part_into_ram`  in  1 each: setup strobes.
- `load_ram_into_current`, `draw_ram`, `draw_apple`, `erase_trail`  in  1 each: draw strobes.
- `update_head`, `inc_check`, `load_head_into_prev`, `load_prev_into_ram`, `load_current_into_prev`  in  1 each: movement strobes.
- `drawStatus`  in  4: pixel index within a 4x4 block; x offset = [1:0], y offset = [3:2].
- `x`  out  8: plot x, 0..159.
- `y`  out  7: plot y, 0..119.
- `colour`  out  3: RGB colour.
- `plot`  out  1: pixel write enable.
- `has_collided`  out  1: single-cycle pulse when the head eats the apple.
- `isDead`  out  1: level; snake has died.

## Operation
Coordinates are `{x[7:0], y[6:0]}` on a 4-pixel grid.
- The sentinel coordinate is x=255, y=127; it is off-screen and never plotted.
- Address register `addr` is LEN_W bits. `reset_address` sets it to 0; `inc_address` adds 1 and wraps. `reset_address` wins if both are asserted.

RAM write priority:
1. `reset_ram`: RAM[addr] <= sentinel.
2. `load_part_into_ram`: RAM[addr] <= cur, then cur.x <= cur.x − 4.
3. `load_prev_into_ram`: RAM[addr] <= prev.

RAM read is combinational: `load_ram_into_current` sets cur <= RAM[addr].

Setup and movement registers:
- `load_default_head`: cur <= (80,60), head <= (80,60), latched direction <= right, isDead <= 0.
- `update_head`: the latched direction takes `dir` unless `dir` is the exact reversal of the latched direction. Then head <= head ± 4 along that axis.
- Leaving the screen (x>156 or y>116 after the step, including underflow) sets isDead.
- `inc_check`:
  - If head == apple: pulse `has_collided` and set apple <= next LFSR value, taken as x = 4·(lfsr mod 40), y = 4·(lfsr[12:8] mod 30).
  - Else if the self-hit flag is set: isDead <= 1.
- `load_head_into_prev`: prev <= head; clears the self-hit flag.
- `load_current_into_prev`: prev <= cur; tail <= cur.
- After the movement loop, `tail` holds the vacated segment.
- Self-hit: during `load_ram_into_current` with addr ≥ 1, if RAM[addr] == head, the self-hit flag is set. It is evaluated at the next `inc_check` of the following frame. Sentinel entries never match.
- The LFSR is a 16-bit Fibonacci LFSR (taps 16,14,13,11) and advances every cycle.

Plot outputs:
- `draw_ram` plots cur in green 3'b010. `draw_apple` plots apple in red 3'b100. `erase_trail` plots tail in black 3'b000.
- The pixel is base + offsets from `drawStatus`.
- `plot` is suppressed when the base is the sentinel.
- `isDead` clears on `reset_ram` or `load_default_head`.

## Timing
- Reset values:
  - x=0, y=0, colour=0, plot=0, has_collided=0, isDead=0.
  - addr=0; head=cur=prev=(80,60); tail=sentinel; apple=(120,60).
  - Latched direction = right; LFSR=LFSR_SEED.
  - RAM contents are not reset; they are cleared by the `reset_ram` sweep.
- x, y, colour and plot are registered: 1-cycle latency from the draw strobe.
- `has_collided` is high exactly 1 cycle, the cycle after `inc_check`. The controller adds 3 to the length per high cycle.
- `isDead` rises the cycle after the triggering strobe and holds until cleared.
- `reset` mid-frame returns all registers to their reset values next edge; partial RAM writes are discarded only by the next `reset_ram` sweep.
- A register update and a RAM read at the same address in one cycle: the read returns the old value.

## Configuration
- `SNAKE_WRAP_EDGES_EN` defined: head wraps modulo 160/120 (x 156+4 → 0, 0−4 → 156; y likewise), and edges never kill.
- Undefined: leaving the screen sets `isDead`, as described above.

## Structure
- Package `snake_pkg`:
  - `coord_t` struct.
  - Constants SCREEN_W=160, SCREEN_H=120, GRID=4, DEFAULT_HEAD, DEFAULT_APPLE, SENTINEL.
  - Colour constants and direction encoding.
- Sub-module `snake_body_ram`: 2^LEN_W × 15 register array with a single write port and a combinational read port.

## Test plan
- Reset, then 512 cycles of `reset_ram`+`inc_address` → every RAM read returns (255,127); `draw_ram` on any entry keeps plot=0.
- `load_default_head`, then 3× (`load_part_into_ram`, `inc_address`) → RAM[0..2] = (80,60), (76,60), (72,60).
- `dir`=right, `update_head` with head (116,60), then `inc_check` with apple (120,60) → has_collided high exactly 1 cycle; apple changes to a grid-aligned on-screen value.
- Head (156,60), `dir`=right, `update_head` → isDead=1 without the macro; head=(0,60) and isDead=0 with it.
- Latched direction right, `dir`=left, `update_head` from (80,60) → head=(84,60).
- `draw_ram` with cur=(40,20), `drawStatus`=4'b1011 → one cycle later x=43, y=22, colour=3'b010, plot=1.
